// File: rtl/alu_nibble_sequencer_pkg.sv
// Shared types and constants for the nibble-serial ALU sequencer and its bench.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // 74LS181 carry pins are active-low: a high level means no carry.
  localparam logic       CARRY_NONE = 1'b1;

  localparam logic [3:0] SEL_ADD = 4'b1001;
  localparam logic [3:0] SEL_SUB = 4'b0110;

endpackage

// File: rtl/alu_nibble_sequencer_if.sv
// Request/response handshake bundle between a producer and the nibble sequencer.
interface alu_nibble_sequencer_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic [3:0]   req_sel;
  logic         req_mode;
  logic         req_cin;
  logic         req_acc;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_f;
  logic         rsp_cout;
  logic         rsp_eq;
  logic         rsp_zero;

  modport master (
    output req_valid, req_a, req_b, req_sel, req_mode, req_cin, req_acc, rsp_ready,
    input  req_ready, rsp_valid, rsp_f, rsp_cout, rsp_eq, rsp_zero
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sel, req_mode, req_cin, req_acc, rsp_ready,
    output req_ready, rsp_valid, rsp_f, rsp_cout, rsp_eq, rsp_zero
  );

endinterface

// File: rtl/alu_nibble_sequencer.sv
// Drives an external 4-bit 74LS181-style ALU one nibble per clock (LSB first, rippled carry).
// Optional accumulator under `ALU_SEQ_ACC_EN: result feeds back as operand A when req_acc=1.
module alu_nibble_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_nibble_sequencer_if.slave bus,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [3:0]           alu_sel,
  output logic                 alu_mode,
  output logic                 alu_cin,
  input  logic [3:0]           alu_f,
  input  logic                 alu_cout,
  input  logic                 alu_eq
);

  localparam int              W    = 4 * NIBBLES;
  localparam int              CW   = $clog2(NIBBLES);
  localparam logic [CW-1:0]   LAST = CW'(NIBBLES - 1);

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_f;
  logic [3:0]     r_sel;
  logic           r_mode;
  logic           r_cin;
  logic           r_carry;
  logic           r_eq;
  logic           r_rsp_valid;

  logic [CW+1:0]  w_base;
  logic [W-1:0]   w_a_load;

  assign w_base = {r_cnt, 2'b00};

`ifdef ALU_SEQ_ACC_EN
  logic [W-1:0]   r_acc;
  assign w_a_load = bus.req_acc ? r_acc : bus.req_a;
`else
  logic           w_unused_acc;
  assign w_unused_acc = bus.req_acc;
  assign w_a_load     = bus.req_a;
`endif

  assign bus.req_ready = (r_state == IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_f     = r_f;
  assign bus.rsp_cout  = r_carry;
  assign bus.rsp_eq    = r_eq;
  assign bus.rsp_zero  = (r_f == '0);

  // ALU pins idle at neutral values so the external part sees no activity outside RUN.
  always_comb begin
    alu_a    = 4'h0;
    alu_b    = 4'h0;
    alu_sel  = 4'h0;
    alu_mode = 1'b0;
    alu_cin  = CARRY_NONE;
    if (r_state == RUN) begin
      alu_a    = r_a[w_base +: 4];
      alu_b    = r_b[w_base +: 4];
      alu_sel  = r_sel;
      alu_mode = r_mode;
      alu_cin  = (r_cnt == '0) ? r_cin : r_carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_f         <= '0;
      r_sel       <= 4'h0;
      r_mode      <= 1'b0;
      r_cin       <= 1'b0;
      r_carry     <= CARRY_NONE;
      r_eq        <= 1'b1;
      r_rsp_valid <= 1'b0;
`ifdef ALU_SEQ_ACC_EN
      r_acc       <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_a     <= w_a_load;
            r_b     <= bus.req_b;
            r_sel   <= bus.req_sel;
            r_mode  <= bus.req_mode;
            r_cin   <= bus.req_cin;
            r_cnt   <= '0;
            r_eq    <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_f[w_base +: 4] <= alu_f;
          r_carry          <= alu_cout;
          r_eq             <= r_eq & alu_eq;
          if (r_cnt == LAST) begin
            r_cnt       <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
`ifdef ALU_SEQ_ACC_EN
            r_acc       <= r_f;
`endif
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_nibble_sequencer.md
# alu_nibble_sequencer

Upstream operand sequencer and result collector for the 4-bit 74LS181-style ALU. Accepts a wide operation (NIBBLES×4-bit operands, function select, mode, carry-in) over a valid/ready handshake, drives the external combinational ALU one nibble per clock from LSB to MSB with ripple carry, assembles the F nibbles into a wide result, and returns result and flags over a second valid/ready handshake. The ALU stays a separate instance wired to the alu_* ports.

## Interface
- NIBBLES, 4, number of 4-bit slices per operation; W = 4*NIBBLES; legal range 2..8
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  operation request valid
- req_ready  output  1  block can accept a request
- req_a  input  W  operand A
- req_b  input  W  operand B
- req_sel  input  4  ALU function select, passed unchanged to every slice
- req_mode  input  1  ALU mode (1 = logic, 0 = arithmetic)
- req_cin  input  1  carry-in to slice 0, ALU-native polarity
- req_acc  input  1  take A from accumulator (see Configuration)
- rsp_valid  output  1  result valid
- rsp_ready  input  1  consumer accepts result
- rsp_f  output  W  assembled result
- rsp_cout  output  1  carry-out of top slice, ALU-native polarity
- rsp_eq  output  1  AND of eqAB over all slices
- rsp_zero  output  1  rsp_f == 0
- alu_a, alu_b  output  4 each  current nibble operands
- alu_sel  output  4;  alu_mode  output  1;  alu_cin  output  1
- alu_f  input  4;  alu_cout  input  1;  alu_eq  input  1  combinational ALU outputs

## Operation
- States: IDLE, RUN, DONE. req_ready = (state == IDLE), combinational.
- IDLE: on req_valid && req_ready, register a, b, sel, mode, cin; clear nibble counter cnt and eq accumulator (set 1); go RUN.
- RUN: alu_a = a_reg[4*cnt +: 4], alu_b likewise; alu_sel/alu_mode from registers; alu_cin = cin_reg when cnt==0, else carry_reg. Each edge: f_reg[4*cnt +: 4] <= alu_f, carry_reg <= alu_cout, eq_reg <= eq_reg & alu_eq, cnt++. After the cnt==NIBBLES-1 edge go DONE.
- Carry chained in both modes; in mode 1 the ALU ignores it, rsp_cout still reports the top-slice value.
- DONE: rsp_valid=1; rsp_f/rsp_cout/rsp_eq stable; rsp_zero = (f_reg == 0). On rsp_ready go IDLE. No accept in the same cycle as result handoff.
- Outside RUN: alu_a=0, alu_b=0, alu_sel=0, alu_mode=0, alu_cin=1.
- Reset (any time, including mid-RUN): state IDLE, cnt=0, all registers 0, carry_reg=1, eq_reg=1; rsp_valid=0, rsp_f=0, rsp_cout=1, rsp_eq=1, rsp_zero=1 during and after reset; req_ready=1. Partial operation discarded, no response issued.

## Timing
- Accept at edge T; slices sampled at edges T+1..T+NIBBLES; rsp_valid high from edge T+NIBBLES until handshake edge.
- Minimum period per operation: NIBBLES+2 cycles (accept, NIBBLES RUN, DONE handshake).
- Request inputs ignored when req_ready=0; consumer stalls hold DONE indefinitely with outputs unchanged.
- ALU combinational path alu_* -> alu_f/alu_cout/alu_eq must close within one clk period.

## Configuration
- ALU_SEQ_ACC_EN defined: W-bit accumulator register updated with rsp_f on every result handshake (reset 0); on accept with req_acc=1, a_reg loads the accumulator instead of req_a.
- Undefined: no accumulator; req_acc port present but ignored; a_reg always loads req_a.

## Structure
- Shared package alu_seq_pkg: state enum (IDLE, RUN, DONE), ALU-native carry constants (CARRY_NONE=1), select constants used by the bench (SEL_ADD=4'b1001, SEL_SUB=4'b0110).
- No sub-module: slice indexing and FSM fit one module; ALU instantiated by the parent.

## Test plan
- Add: A=0x1234, B=0x1111, sel=1001, mode=0, cin=1 -> rsp_f=0x2345, rsp_cout=1, rsp_valid 4 cycles after accept.
- Carry ripple: A=0xFFFF, B=0x0001, sel=1001, mode=0, cin=1 -> rsp_f=0x0000, rsp_cout=0, rsp_zero=1.
- Compare: A=B=0xA5A5, sel=0110, mode=0, cin=1 -> rsp_f=0xFFFF, rsp_eq=1; with B=0xA5A4 -> rsp_eq=0.
- Logic + backpressure: A=0xF0F0, B=0xFF00, sel=0110, mode=1, rsp_ready low 5 cycles -> rsp_f=0x0FF0 held stable, req_ready=0 throughout, returns to IDLE one edge after rsp_ready.
- Reset mid-RUN: assert rst_n low after 2 slices -> immediate IDLE, rsp_valid=0, next request A=0x0001, B=0x0001, add -> rsp_f=0x0002.
- ALU_SEQ_ACC_EN: first add 0x0003+0x0004, then req_acc=1, B=0x0010 -> second rsp_f=0x0017.
